debounced_pio: RTL and testbench

DEBOUNCED_PIO -- requirements
Module: debounced_pio

---
 rtl/debounced_pio.sv | 123 ++++++++++++
 tb/tb_debounced_pio.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/debounced_pio.sv
// Debounced parallel input port: 2-flop synchronisers, per-channel stability counters,
// edge capture with write-1-to-clear, interrupt mask and a 4-word register slave.
module debounced_pio #(
    parameter int unsigned     WIDTH           = 18,
    parameter int unsigned     DEBOUNCE_CYCLES = 50000,
    parameter int unsigned     EDGE_TYPE       = 2,
    parameter logic [WIDTH-1:0] IDLE_LEVEL     = '0
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic [WIDTH-1:0] in_port,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE = 2'd2;
    localparam logic [1:0] ADDR_RAW  = 2'd3;

    logic [WIDTH-1:0] sync_meta;
    logic [WIDTH-1:0] sync_raw;
    logic [WIDTH-1:0] debounced;
    logic [WIDTH-1:0] debounced_d;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [CNT_W-1:0] stable_cnt [WIDTH];

    logic [CNT_W-1:0] next_cnt_c [WIDTH];
    logic [WIDTH-1:0] next_debounced_c;
    logic [WIDTH-1:0] edge_set_c;
    logic [WIDTH-1:0] edge_clear_c;
    logic [31:0]      read_mux_c;
    logic             wr_en_c;
    logic             rd_en_c;
    logic             unused_c;

    assign wr_en_c  = chipselect & write;
    assign rd_en_c  = chipselect & read;
    assign unused_c = &{1'b0, writedata};

    // A channel accepts the synchronised level only after DEBOUNCE_CYCLES consecutive mismatches.
    always_comb begin
        next_debounced_c = debounced;
        for (int i = 0; i < int'(WIDTH); i++) begin
            next_cnt_c[i] = '0;
            if (sync_raw[i] != debounced[i]) begin
                if (stable_cnt[i] == CNT_LAST) begin
                    next_debounced_c[i] = sync_raw[i];
                end else begin
                    next_cnt_c[i] = stable_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        case (EDGE_TYPE)
            0:       edge_set_c = debounced & ~debounced_d;
            1:       edge_set_c = ~debounced & debounced_d;
            default: edge_set_c = debounced ^ debounced_d;
        endcase
    end

    always_comb begin
        edge_clear_c = '0;
        if (wr_en_c && address == ADDR_EDGE) begin
            edge_clear_c = writedata[WIDTH-1:0];
        end
    end

    always_comb begin
        case (address)
            ADDR_DATA: read_mux_c = 32'(debounced);
            ADDR_MASK: read_mux_c = 32'(irq_mask);
            ADDR_EDGE: read_mux_c = 32'(edge_capture);
            ADDR_RAW:  read_mux_c = 32'(sync_raw);
            default:   read_mux_c = '0;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync_meta    <= IDLE_LEVEL;
            sync_raw     <= IDLE_LEVEL;
            debounced    <= IDLE_LEVEL;
            debounced_d  <= IDLE_LEVEL;
            irq_mask     <= '0;
            edge_capture <= '0;
            readdata     <= '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                stable_cnt[i] <= '0;
            end
        end else begin
            sync_meta   <= in_port;
            sync_raw    <= sync_meta;
            debounced   <= next_debounced_c;
            debounced_d <= debounced;
            for (int i = 0; i < int'(WIDTH); i++) begin
                stable_cnt[i] <= next_cnt_c[i];
            end
            // A fresh edge outranks a simultaneous clear of the same bit.
            edge_capture <= (edge_capture & ~edge_clear_c) | edge_set_c;
            if (wr_en_c && address == ADDR_MASK) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            if (rd_en_c) begin
                readdata <= read_mux_c;
            end
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_debounced_pio.sv
// Directed bench for debounced_pio with WIDTH=4, DEBOUNCE_CYCLES=4, any-edge capture.
module tb_debounced_pio;

    logic        clk_clk;
    logic        reset_reset;
    logic [3:0]  in_port;
    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    int errors;
    int checks;

    debounced_pio #(
        .WIDTH          (4),
        .DEBOUNCE_CYCLES(4),
        .EDGE_TYPE      (2),
        .IDLE_LEVEL     (4'h0)
    ) dut (
        .clk_clk    (clk_clk),
        .reset_reset(reset_reset),
        .in_port    (in_port),
        .address    (address),
        .chipselect (chipselect),
        .read       (read),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(posedge clk_clk); #1;
        chipselect = 1'b1; read = 1'b1; address = a;
        @(posedge clk_clk); #1;
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk_clk); #1;
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(posedge clk_clk); #1;
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset_reset = 1'b1;
        in_port = 4'h0;
        repeat (3) @(posedge clk_clk);
        #1;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq_during got=%b exp=0", irq); end
        reset_reset = 1'b0;
        checks++;
        if (readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata got=%h exp=0", readdata); end
        bus_read(2'd0, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", d); end
        bus_read(2'd2, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_edgecap got=%h exp=0", d); end
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_mask got=%h exp=0", d); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
    endtask

    task automatic test_rise_bit0();
        logic [31:0] d;
        @(posedge clk_clk); #1;
        in_port[0] = 1'b1;
        chipselect = 1'b1; read = 1'b1; address = 2'd0;
        // debounced updates on edge 6, read path shows it on edge 7
        for (int n = 1; n <= 7; n++) begin
            @(posedge clk_clk); #1;
            checks++;
            if (readdata !== ((n >= 7) ? 32'h1 : 32'h0)) begin
                errors++; $display("FAIL rise_bit0_cycle%0d got=%h exp=%h", n, readdata, (n >= 7) ? 32'h1 : 32'h0);
            end
        end
        chipselect = 1'b0; read = 1'b0;
        bus_read(2'd2, d);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL rise_bit0_edgecap got=%h exp=1", d); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL rise_bit0_irq_masked got=%b exp=0", irq); end
        bus_write(2'd2, 32'h1);
        bus_read(2'd2, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rise_bit0_w1c got=%h exp=0", d); end
    endtask

    task automatic test_glitch_bit1();
        logic [31:0] d;
        @(posedge clk_clk); #1;
        in_port[1] = 1'b1;
        chipselect = 1'b1; read = 1'b1; address = 2'd0;
        // sampled high on edges 1-3, low on 4, high from 5: accepted on edge 10
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk_clk); #1;
            checks++;
            if (readdata !== ((n >= 11) ? 32'h3 : 32'h1)) begin
                errors++; $display("FAIL glitch_bit1_cycle%0d got=%h exp=%h", n, readdata, (n >= 11) ? 32'h3 : 32'h1);
            end
            in_port[1] = (n != 3);
        end
        chipselect = 1'b0; read = 1'b0;
        bus_read(2'd2, d);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL glitch_bit1_edgecap got=%h exp=2", d); end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        bus_write(2'd2, 32'hF);
        bus_read(2'd2, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL irq_clear_all got=%h exp=0", d); end
        bus_write(2'd1, 32'h1);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_before_edge got=%b exp=0", irq); end
        in_port[0] = 1'b0;
        repeat (8) @(posedge clk_clk);
        #1;
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_on_fall got=%b exp=1", irq); end
        bus_read(2'd2, d);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL irq_edgecap got=%h exp=1", d); end
        bus_write(2'd2, 32'h1);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_w1c got=%b exp=0", irq); end
        bus_read(2'd2, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL irq_edgecap_cleared got=%h exp=0", d); end
    endtask

    task automatic test_regs();
        logic [31:0] d;
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'hF) begin errors++; $display("FAIL regs_mask_width got=%h exp=f", d); end
        bus_write(2'd0, 32'hF);
        bus_read(2'd0, d);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL regs_data_ro got=%h exp=2", d); end
        bus_read(2'd3, d);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL regs_raw got=%h exp=2", d); end
        @(posedge clk_clk); #1;
        chipselect = 1'b1; read = 1'b1; write = 1'b1; address = 2'd1; writedata = 32'h5;
        @(posedge clk_clk); #1;
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
        checks++;
        if (readdata !== 32'hF) begin errors++; $display("FAIL regs_rw_prewrite got=%h exp=f", readdata); end
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h5) begin errors++; $display("FAIL regs_mask_written got=%h exp=5", d); end
        repeat (3) @(posedge clk_clk);
        #1;
        checks++;
        if (readdata !== 32'h5) begin errors++; $display("FAIL regs_readdata_hold got=%h exp=5", readdata); end
    endtask

    task automatic test_w1c_collision();
        logic [31:0] d;
        @(posedge clk_clk); #1;
        in_port[2] = 1'b1;
        // debounced changes on edge 6, edgecapture sets on edge 7 together with the clear
        repeat (6) @(posedge clk_clk);
        #1;
        chipselect = 1'b1; write = 1'b1; address = 2'd2; writedata = 32'h4;
        @(posedge clk_clk); #1;
        chipselect = 1'b0; write = 1'b0;
        bus_read(2'd2, d);
        checks++;
        if (d !== 32'h4) begin errors++; $display("FAIL w1c_collision_set_wins got=%h exp=4", d); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL w1c_collision_irq got=%b exp=1", irq); end
        bus_write(2'd2, 32'h4);
        bus_read(2'd2, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL w1c_plain_clear got=%h exp=0", d); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL w1c_plain_irq got=%b exp=0", irq); end
    endtask

    task automatic test_reset_mid_debounce();
        logic [31:0] d;
        @(posedge clk_clk); #1;
        in_port[3] = 1'b1;
        repeat (4) @(posedge clk_clk);
        #1;
        reset_reset = 1'b1;
        @(posedge clk_clk); #1;
        reset_reset = 1'b0;
        checks++;
        if (readdata !== 32'h0) begin errors++; $display("FAIL midrst_readdata got=%h exp=0", readdata); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL midrst_irq got=%b exp=0", irq); end
        chipselect = 1'b1; read = 1'b1; address = 2'd0;
        // bits 1..3 differ from idle and are accepted together 6 edges after the reset edge
        for (int n = 1; n <= 7; n++) begin
            @(posedge clk_clk); #1;
            checks++;
            if (readdata !== ((n >= 7) ? 32'hE : 32'h0)) begin
                errors++; $display("FAIL midrst_cycle%0d got=%h exp=%h", n, readdata, (n >= 7) ? 32'hE : 32'h0);
            end
        end
        chipselect = 1'b0; read = 1'b0;
        bus_read(2'd2, d);
        checks++;
        if (d !== 32'hE) begin errors++; $display("FAIL midrst_edgecap got=%h exp=e", d); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL midrst_irq_mask_cleared got=%b exp=0", irq); end
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        clk_clk     = 1'b0;
        reset_reset = 1'b1;
        in_port     = 4'h0;
        address     = 2'd0;
        chipselect  = 1'b0;
        read        = 1'b0;
        write       = 1'b0;
        writedata   = 32'h0;

        test_reset();
        test_rise_bit0();
        test_glitch_bit1();
        test_irq();
        test_regs();
        test_w1c_collision();
        test_reset_mid_debounce();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
